// File: rtl/rv_fetch_pkg.sv
// Shared fetch-path types and constants: FSM states, queue entry layout, PC defaults.
package rv_fetch_pkg;

  localparam int unsigned FetchXlen = 32;
  localparam logic [31:0] ResetPc   = 32'h0000_0000;
  localparam int unsigned PcStep    = 4;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDrop
  } fetch_state_e;

  typedef struct packed {
    logic [FetchXlen-1:0] pc;
    logic [FetchXlen-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage, flush, occupancy count and full/empty flags.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A write into a full queue is only legal alongside a pop of the head slot.
  assign wr_en = push_i && !flush_i && (!full_o || pop_i);
  assign rd_en = pop_i && !flush_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_en && !rd_en)      count_q <= count_q + CW'(1);
      else if (!wr_en && rd_en) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  push_when_full_a : assert property (@(posedge clk) disable iff (rst)
    (push_i && !flush_i && full_o) |-> pop_i)
    else $error("sync_fifo: push into full queue without pop");

endmodule

// File: rtl/if_prefetch_queue.sv
// Decoupled instruction fetcher: one outstanding memory request feeding a prefetch queue,
// with redirect flush and discard of a stale in-flight response.
module if_prefetch_queue
  import rv_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = FetchXlen,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(ResetPc),
  parameter int unsigned     PC_STEP  = PcStep
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     inst_ce_o,
  output logic [XLEN-1:0]          inst_addr_o,
  input  logic                     inst_gnt_i,
  input  logic                     inst_valid_i,
  input  logic [XLEN-1:0]          inst_i,
  input  logic                     redirect_i,
  input  logic [XLEN-1:0]          redirect_addr_i,
  output logic                     id_valid_o,
  input  logic                     id_ready_i,
  output logic [XLEN-1:0]          id_pc_o,
  output logic [XLEN-1:0]          id_inst_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned LW  = $clog2(DEPTH) + 1;
  localparam int unsigned LW1 = LW + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            push, pop, full, empty;
  logic [LW-1:0]   count;
  logic [2*XLEN-1:0] head;
  logic [LW1-1:0]  level_after_push;

  assign inst_ce_o   = (state_q == StReq);
  assign inst_addr_o = fetch_pc_q;

  assign push = (state_q == StWait) && inst_valid_i && !redirect_i;
  assign pop  = id_ready_i && !empty && !redirect_i;

  // Occupancy once this response lands, so the next request is only issued if it fits.
  assign level_after_push = {1'b0, count} + LW1'(1) - LW1'(pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    unique case (state_q)
      StIdle: if (!full) state_d = StReq;
      StReq: begin
        if (inst_gnt_i) begin
          state_d    = StWait;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
        end
      end
      StWait: begin
        if (inst_valid_i) state_d = (level_after_push < LW1'(DEPTH)) ? StReq : StIdle;
      end
      StDrop: if (inst_valid_i) state_d = StReq;
      default: state_d = StIdle;
    endcase

    // A request still owed a response after the redirect must be drained in StDrop.
    if (redirect_i) begin
      fetch_pc_d = redirect_addr_i;
      if ((state_q == StReq && inst_gnt_i) ||
          ((state_q == StWait || state_q == StDrop) && !inst_valid_i)) begin
        state_d = StDrop;
      end else begin
        state_d = StReq;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  sync_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_i),
    .push_i  (push),
    .wdata_i ({req_pc_q, inst_i}),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign id_valid_o = !empty;
  assign id_pc_o    = empty ? '0 : head[2*XLEN-1:XLEN];
  assign id_inst_o  = empty ? '0 : head[XLEN-1:0];
  assign level_o    = count;

endmodule
